// File: rtl/hoop_game_sequencer_if.sv
// Signal bundle between the hoop game sequencer and its surroundings.
// The master modport is the environment side; the slave modport is the sequencer.
interface hoop_game_sequencer_if;
  logic       i_start;
  logic       i_mode_sel;
  logic       i_hoop_in;
  logic [7:0] o_score;
  logic [7:0] o_time_val;
  logic       o_game_mode;
  logic       o_playing;
  logic       o_game_over;
  logic       o_lb_we;
  logic       o_lb_sel;
  logic [7:0] o_lb_data;
  logic       o_tick;

  modport master (
    output i_start, i_mode_sel, i_hoop_in,
    input  o_score, o_time_val, o_game_mode, o_playing, o_game_over,
    input  o_lb_we, o_lb_sel, o_lb_data, o_tick
  );

  modport slave (
    input  i_start, i_mode_sel, i_hoop_in,
    output o_score, o_time_val, o_game_mode, o_playing, o_game_over,
    output o_lb_we, o_lb_sel, o_lb_data, o_tick
  );
endinterface

// File: rtl/hoop_game_sequencer.sv
// Game-flow controller: input sync, score/time keeping and one leaderboard write per game.
// Define HOOP_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter on the hoop sensor.
module hoop_game_sequencer #(
  parameter int unsigned TICK_CYCLES     = 50000000,
  parameter int unsigned GAME_SECONDS    = 30,
  parameter int unsigned TARGET_SCORE    = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input logic                  i_clock,
  input logic                  i_reset,
  hoop_game_sequencer_if.slave bus
);

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TickW-1:0] TickMax    = TickW'(TICK_CYCLES - 1);
  localparam logic [7:0]       GameTime   = 8'(GAME_SECONDS);
  localparam logic [7:0]       TargetPts  = 8'(TARGET_SCORE);

  typedef enum logic [1:0] {StIdle, StPlay, StCommit, StDone} state_e;

  // Input synchronisers and edge detectors
  logic r_start_s1, r_start_s2, r_start_prev;
  logic r_hoop_s1, r_hoop_s2, r_hoop_prev;
  logic w_hoop_lvl;
  logic w_start_evt, w_hoop_evt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_prev <= 1'b0;
      r_hoop_s1    <= 1'b0;
      r_hoop_s2    <= 1'b0;
      r_hoop_prev  <= 1'b0;
    end else begin
      r_start_s1   <= bus.i_start;
      r_start_s2   <= r_start_s1;
      r_start_prev <= r_start_s2;
      r_hoop_s1    <= bus.i_hoop_in;
      r_hoop_s2    <= r_hoop_s1;
      r_hoop_prev  <= w_hoop_lvl;
    end
  end

`ifdef HOOP_DEBOUNCE_EN
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  logic [DbW-1:0] r_db_cnt;
  logic           r_hoop_filt;

  // Any return to the filtered level restarts the stability count.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_db_cnt    <= '0;
      r_hoop_filt <= 1'b0;
    end else if (r_hoop_s2 == r_hoop_filt) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DbMax) begin
      r_db_cnt    <= '0;
      r_hoop_filt <= r_hoop_s2;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_hoop_lvl = r_hoop_filt;
`else
  logic w_unused_debounce;
  assign w_unused_debounce = ^DEBOUNCE_CYCLES;
  assign w_hoop_lvl        = r_hoop_s2;
`endif

  assign w_start_evt = r_start_s2 & ~r_start_prev;
  assign w_hoop_evt  = w_hoop_lvl & ~r_hoop_prev;

  // State and registered outputs
  state_e           r_state, w_state_d;
  logic [TickW-1:0] r_tick_cnt, w_tick_cnt_d;
  logic [7:0]       r_score, w_score_d;
  logic [7:0]       r_time, w_time_d;
  logic             r_mode, w_mode_d;
  logic             r_playing, r_game_over;
  logic             r_tick, w_tick_d;
  logic             r_lb_we, w_lb_we_d;
  logic             r_lb_sel, w_lb_sel_d;
  logic [7:0]       r_lb_data, w_lb_data_d;
  logic             w_tick_wrap;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_tick_cnt  <= '0;
      r_score     <= 8'd0;
      r_time      <= GameTime;
      r_mode      <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
      r_tick      <= 1'b0;
      r_lb_we     <= 1'b0;
      r_lb_sel    <= 1'b0;
      r_lb_data   <= 8'd0;
    end else begin
      r_state     <= w_state_d;
      r_tick_cnt  <= w_tick_cnt_d;
      r_score     <= w_score_d;
      r_time      <= w_time_d;
      r_mode      <= w_mode_d;
      r_playing   <= (w_state_d == StPlay);
      r_game_over <= (w_state_d == StDone);
      r_tick      <= w_tick_d;
      r_lb_we     <= w_lb_we_d;
      r_lb_sel    <= w_lb_sel_d;
      r_lb_data   <= w_lb_data_d;
    end
  end

  assign w_tick_wrap = (r_tick_cnt == TickMax);

  always_comb begin
    w_state_d    = r_state;
    w_tick_cnt_d = r_tick_cnt;
    w_score_d    = r_score;
    w_time_d     = r_time;
    w_mode_d     = r_mode;
    w_tick_d     = 1'b0;
    w_lb_we_d    = 1'b0;
    w_lb_sel_d   = r_lb_sel;
    w_lb_data_d  = r_lb_data;

    unique case (r_state)
      StIdle: begin
        w_score_d    = 8'd0;
        w_mode_d     = bus.i_mode_sel;
        w_time_d     = bus.i_mode_sel ? 8'd0 : GameTime;
        w_tick_cnt_d = '0;
        if (w_start_evt) begin
          w_state_d = StPlay;
        end
      end

      StPlay: begin
        w_tick_cnt_d = w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
        w_tick_d     = w_tick_wrap;
        if (w_hoop_evt && (r_score != 8'hff)) begin
          w_score_d = r_score + 8'd1;
        end
        if (!r_mode) begin
          if (w_tick_wrap) begin
            w_time_d = r_time - 8'd1;
            if (r_time == 8'd1) begin
              w_state_d = StCommit;
            end
          end
        end else begin
          if (w_tick_wrap && (r_time != 8'hff)) begin
            w_time_d = r_time + 8'd1;
          end
          if (w_hoop_evt && (w_score_d == TargetPts)) begin
            w_state_d = StCommit;
          end
        end
        // Capture next-state values so a same-cycle basket or tick is included.
        if (w_state_d == StCommit) begin
          w_lb_we_d   = 1'b1;
          w_lb_sel_d  = r_mode;
          w_lb_data_d = r_mode ? w_time_d : w_score_d;
        end
      end

      StCommit: begin
        w_state_d = StDone;
      end

      StDone: begin
        if (w_start_evt) begin
          w_state_d = StIdle;
          w_score_d = 8'd0;
          w_mode_d  = bus.i_mode_sel;
          w_time_d  = bus.i_mode_sel ? 8'd0 : GameTime;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign bus.o_score     = r_score;
  assign bus.o_time_val  = r_time;
  assign bus.o_game_mode = r_mode;
  assign bus.o_playing   = r_playing;
  assign bus.o_game_over = r_game_over;
  assign bus.o_tick      = r_tick;
  assign bus.o_lb_we     = r_lb_we;
  assign bus.o_lb_sel    = r_lb_sel;
  assign bus.o_lb_data   = r_lb_data;

endmodule

// File: tb/tb_hoop_game_sequencer.sv
// Self-checking bench for hoop_game_sequencer: directed game table, corner sequences
// and randomized games checked against an event-time reference model.
module tb_hoop_game_sequencer;
  localparam int unsigned TickCycles  = 10;
  localparam int unsigned GameSeconds = 3;
  localparam int unsigned TargetScore = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hoop_game_sequencer_if bus ();

  hoop_game_sequencer #(
    .TICK_CYCLES    (TickCycles),
    .GAME_SECONDS   (GameSeconds),
    .TARGET_SCORE   (TargetScore),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int we_cnt, we_off, we_data, we_sel;

  // hmask bit k: a basket whose score update lands k edges after PLAY entry.
  typedef struct packed {
    logic        mode;
    logic [63:0] hmask;
    logic        exp_sel;
    logic [7:0]  exp_data;
    logic [7:0]  exp_off;
    logic [7:0]  exp_score;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_step(input bit st, input bit hp);
    bus.i_start   = st;
    bus.i_hoop_in = hp;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_step(1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit mode);
    rst            = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_hoop_in  = 1'b0;
    bus.i_mode_sel = mode;
    step();
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  // Start at j=0; hoop level per mask bit; PLAY entry is 3 edges after start is driven.
  task automatic run_game(input bit mode, input logic [63:0] hmask);
    do_reset(mode);
    we_cnt  = 0;
    we_off  = -1;
    we_data = -1;
    we_sel  = -1;
    for (int j = 0; j < 64; j++) begin
      if (bus.o_lb_we) begin
        we_cnt++;
        if (we_cnt == 1) begin
          we_off  = j - 3;
          we_data = int'(bus.o_lb_data);
          we_sel  = int'(bus.o_lb_sel);
        end
      end
      drive_step(j == 0, hmask[j]);
    end
    bus.i_hoop_in = 1'b0;
  endtask

  // Reference: timed games count baskets landing within the game length;
  // race games end on the TargetScore-th basket, time = whole seconds elapsed.
  function automatic void model(input bit mode, input logic [63:0] m,
                                output int off, output int data, output int score);
    int ks[$];
    for (int k = 1; k < 64; k++) if (m[k]) ks.push_back(k);
    if (!mode) begin
      off  = GameSeconds * TickCycles;
      data = 0;
      foreach (ks[i]) if (ks[i] <= off) data++;
      score = data;
    end else begin
      off   = ks[TargetScore-1];
      data  = off / TickCycles;
      score = TargetScore;
    end
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  logic [63:0] rmask;
  int          rk, e_off, e_data, e_score;
  bit          rmode;

  initial begin
    vecs[0] = '{mode: 1'b0, hmask: 64'h0000_0000_0040_8420, exp_sel: 1'b0,
                exp_data: 8'd4, exp_off: 8'd30, exp_score: 8'd4};
    vecs[1] = '{mode: 1'b1, hmask: 64'h0000_0000_0200_1000, exp_sel: 1'b1,
                exp_data: 8'd2, exp_off: 8'd25, exp_score: 8'd2};
    vecs[2] = '{mode: 1'b0, hmask: 64'h0000_0002_4000_0100, exp_sel: 1'b0,
                exp_data: 8'd2, exp_off: 8'd30, exp_score: 8'd2};
    vecs[3] = '{mode: 1'b1, hmask: 64'h0000_0000_0010_0010, exp_sel: 1'b1,
                exp_data: 8'd2, exp_off: 8'd20, exp_score: 8'd2};
    vecs[4] = '{mode: 1'b0, hmask: 64'h0, exp_sel: 1'b0,
                exp_data: 8'd0, exp_off: 8'd30, exp_score: 8'd0};
    vecs[5] = '{mode: 1'b1, hmask: 64'h0000_0100_0000_0048, exp_sel: 1'b1,
                exp_data: 8'd0, exp_off: 8'd6, exp_score: 8'd2};

    bus.i_start    = 1'b0;
    bus.i_hoop_in  = 1'b0;
    bus.i_mode_sel = 1'b0;
    step();
    step();
    check("reset score", int'(bus.o_score), 0);
    check("reset time_val", int'(bus.o_time_val), GameSeconds);
    check("reset game_mode", int'(bus.o_game_mode), 0);
    check("reset playing", int'(bus.o_playing), 0);
    check("reset game_over", int'(bus.o_game_over), 0);
    check("reset lb_we", int'(bus.o_lb_we), 0);
    check("reset lb_sel", int'(bus.o_lb_sel), 0);
    check("reset lb_data", int'(bus.o_lb_data), 0);
    check("reset tick", int'(bus.o_tick), 0);

    // Directed game table
    for (int i = 0; i < 6; i++) begin
      run_game(vecs[i].mode, vecs[i].hmask);
      check($sformatf("vec%0d lb_we count", i), we_cnt, 1);
      check($sformatf("vec%0d lb_we offset", i), we_off, int'(vecs[i].exp_off));
      check($sformatf("vec%0d lb_sel", i), we_sel, int'(vecs[i].exp_sel));
      check($sformatf("vec%0d lb_data", i), we_data, int'(vecs[i].exp_data));
      check($sformatf("vec%0d final score", i), int'(bus.o_score), int'(vecs[i].exp_score));
      check($sformatf("vec%0d game_over", i), int'(bus.o_game_over), 1);
    end

    // Timed game: tick timing, start ignored in PLAY, hoop ignored in DONE, restart
    do_reset(1'b0);
    drive_step(1'b1, 1'b0);
    idle(2);
    check("seq playing at entry", int'(bus.o_playing), 1);
    check("seq time at entry", int'(bus.o_time_val), 3);
    idle(2);
    drive_step(1'b0, 1'b1);
    drive_step(1'b1, 1'b0);
    idle(5);
    check("seq tick before first", int'(bus.o_tick), 0);
    check("seq time before first tick", int'(bus.o_time_val), 3);
    check("seq score after hoop", int'(bus.o_score), 1);
    idle(1);
    check("seq first tick", int'(bus.o_tick), 1);
    check("seq time after tick1", int'(bus.o_time_val), 2);
    check("seq start ignored", int'(bus.o_playing), 1);
    idle(10);
    check("seq time after tick2", int'(bus.o_time_val), 1);
    idle(10);
    check("seq lb_we at final tick", int'(bus.o_lb_we), 1);
    check("seq lb_data", int'(bus.o_lb_data), 1);
    check("seq time at commit", int'(bus.o_time_val), 0);
    idle(1);
    check("seq game_over", int'(bus.o_game_over), 1);
    check("seq lb_we drops", int'(bus.o_lb_we), 0);
    drive_step(1'b0, 1'b1);
    idle(5);
    check("seq hoop ignored in done", int'(bus.o_score), 1);
    drive_step(1'b1, 1'b0);
    idle(2);
    check("seq done->idle game_over", int'(bus.o_game_over), 0);
    check("seq done->idle score", int'(bus.o_score), 0);
    check("seq done->idle playing", int'(bus.o_playing), 0);
    drive_step(1'b1, 1'b0);
    idle(2);
    check("seq second game playing", int'(bus.o_playing), 1);

    // Reset mid-PLAY
    do_reset(1'b0);
    drive_step(1'b1, 1'b0);
    idle(2);
    drive_step(1'b0, 1'b1);
    idle(3);
    check("rst score before", int'(bus.o_score), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst playing", int'(bus.o_playing), 0);
    check("rst score", int'(bus.o_score), 0);
    check("rst time_val", int'(bus.o_time_val), 3);
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_lb_we) we_cnt++;
      step();
    end
    check("rst no lb_we", we_cnt, 0);

`ifdef HOOP_DEBOUNCE_EN
    // Bouncing sensor settles to one basket
    do_reset(1'b0);
    drive_step(1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      drive_step(1'b0, 1'b1);
      drive_step(1'b0, 1'b1);
      drive_step(1'b0, 1'b0);
      drive_step(1'b0, 1'b0);
    end
    check("debounce bounce no score", int'(bus.o_score), 0);
    for (int i = 0; i < 10; i++) drive_step(1'b0, 1'b1);
    check("debounce one basket", int'(bus.o_score), 1);
    bus.i_hoop_in = 1'b0;
`endif

    // Randomized games against the reference model
    for (int g = 0; g < 40; g++) begin
      rmode = 1'($urandom_range(1, 0));
      rmask = '0;
      rk    = int'($urandom_range(10, 1));
      while (rk < 56) begin
        rmask[rk] = 1'b1;
        rk += int'($urandom_range(12, 2));
      end
      model(rmode, rmask, e_off, e_data, e_score);
      run_game(rmode, rmask);
      check($sformatf("rnd%0d lb_we count", g), we_cnt, 1);
      check($sformatf("rnd%0d lb_we offset", g), we_off, e_off);
      check($sformatf("rnd%0d lb_sel", g), we_sel, int'(rmode));
      check($sformatf("rnd%0d lb_data", g), we_data, e_data);
      check($sformatf("rnd%0d final score", g), int'(bus.o_score), e_score);
      check($sformatf("rnd%0d game_over", g), int'(bus.o_game_over), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hoop_game_sequencer.md
# hoop_game_sequencer

Game-flow controller for the hoop scoring system. It synchronises the raw hoop sensor and start button, then sequences a game through idle, play, leaderboard-commit and done. It owns the score counter and the one-second game clock, and issues a single write to the score or time leaderboard at the end of each game. It drives the seven-segment/VGA score and time paths and replaces the ad-hoc timing glue in the top level.

## Interface
Parameters:
- TICK_CYCLES, 50000000: clock cycles per game second (1 s at 50 MHz).
- GAME_SECONDS, 30: length of a timed-mode game in seconds, 1..255.
- TARGET_SCORE, 10: score that ends a race-mode game, 1..255.
- DEBOUNCE_CYCLES, 500000: hoop-sensor stable time; only used when debounce is compiled in.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and every output to its reset value.
- start  in  1  raw start button; two-flop synchronised and rising-edge detected.
- mode_sel  in  1  0 = timed mode (score in GAME_SECONDS), 1 = race mode (time to TARGET_SCORE).
- hoop_in  in  1  raw hoop sensor, asynchronous; a rising edge is one basket.
- score  out  8  current basket count. Reset value 0.
- time_val  out  8  timed mode: seconds remaining; race mode: seconds elapsed. Reset value GAME_SECONDS.
- game_mode  out  1  mode latched at game start. Reset value 0.
- playing  out  1  high in PLAY. Reset value 0.
- game_over  out  1  high in DONE. Reset value 0.
- lb_we  out  1  one-cycle leaderboard write strobe. Reset value 0.
- lb_sel  out  1  0 = score leaderboard, 1 = time leaderboard. Reset value 0.
- lb_data  out  8  value to insert; valid while lb_we is high. Reset value 0.
- tick  out  1  one-cycle pulse per game second, only in PLAY. Reset value 0.

## Operation
- Sensor path: hoop_in passes through two sync flops, then the optional debouncer, then a rising-edge detector, producing hoop_evt. start uses the same path without debounce, producing start_evt.
- IDLE:
  - score = 0.
  - game_mode follows mode_sel.
  - time_val = GAME_SECONDS when mode_sel = 0, else 0.
  - start_evt latches game_mode, clears the tick counter and enters PLAY.
- PLAY:
  - The tick counter counts 0..TICK_CYCLES-1. tick pulses when the counter equals TICK_CYCLES-1, and the counter wraps to 0.
  - hoop_evt increments score, saturating at 255.
  - Timed mode: each tick decrements time_val. The tick that brings time_val to 0 moves the FSM to COMMIT.
  - Race mode: each tick increments time_val, saturating at 255. The cycle in which score becomes TARGET_SCORE moves the FSM to COMMIT.
  - start_evt is ignored.
- COMMIT (exactly one cycle):
  - lb_we = 1 and lb_sel = game_mode.
  - lb_data = score in timed mode, time_val in race mode.
  - Next state is DONE.
- DONE:
  - score and time_val hold; game_over = 1.
  - hoop_evt is ignored.
  - start_evt returns the FSM to IDLE; a further start_evt then begins a new game.
- Simultaneous events:
  - Timed mode, hoop_evt in the same cycle as the final tick: the basket counts, and lb_data includes it.
  - Race mode, tick in the same cycle as the target basket: time_val increments, and lb_data includes the increment.
- Reset in any state, including mid-PLAY or in COMMIT: next cycle is IDLE with reset values, and no lb_we is issued.

## Timing
- hoop_in rise → score update: 3 clock edges without debounce; 3 + DEBOUNCE_CYCLES edges with debounce.
- start rise → playing high: 3 edges.
- First tick: TICK_CYCLES cycles after entry to PLAY.
- Final tick (timed) or target basket (race) → lb_we: 1 cycle later. lb_we → game_over: 1 cycle later.
- At most one lb_we per game. lb_data and lb_sel are stable in the lb_we cycle.
- All outputs are registered.

## Configuration
- HOOP_DEBOUNCE_EN defined: the synchronised hoop level updates the filtered level only after it has differed from the filtered level for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count, so one physical basket gives one hoop_evt.
- HOOP_DEBOUNCE_EN undefined: the debouncer and its counter are absent, and every synchronised rising edge is a basket.

## Test plan
Bench parameters: TICK_CYCLES=10, GAME_SECONDS=3, TARGET_SCORE=2, debounce off.
- Timed game: mode_sel=0, start pulse, 4 hoop pulses inside 30 cycles → time_val 3→2→1→0 on ticks; lb_we single pulse with lb_sel=0, lb_data=4; game_over=1.
- Race game: mode_sel=1, hoops at cycles 12 and 25 after PLAY → time_val=2 at commit; lb_we with lb_sel=1, lb_data=2.
- Simultaneous: timed mode, hoop_evt aligned with the 3rd tick → score and lb_data include that basket (lb_data = prior+1).
- Reset mid-PLAY with score=1 → next cycle playing=0, score=0, time_val=3; lb_we never asserted.
- Ignored inputs: start during PLAY and hoops during DONE → no state change, score unchanged; start in DONE → IDLE, score cleared.
- HOOP_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: hoop_in toggling every 2 cycles, then held high → exactly one score increment.
